sample_readout_scheduler: RTL

Round-robin scheduler that shares one parallel readout path among the per-channel serial sample buffers. It grants one requesting channel at a time and strobes that channel's buffer shift for one burst. It deserialises the head bits into a sample word and presents the word downstream on a valid/ready handshake. It sits between the channel shift buffers and the output formatter.

---
 rtl/sample_readout_scheduler_if.sv | 28 ++
 rtl/sample_readout_scheduler.sv | 131 +++++++++++++
 2 files changed

// File: rtl/sample_readout_scheduler_if.sv
// Readout bundle between channel buffers, scheduler and output formatter.
// master: scheduler side; slave: buffers/downstream side.
interface sample_readout_scheduler_if #(
  parameter int NUM_CH    = 7,
  parameter int BURST_LEN = 8
) ();
  localparam int PW = $clog2(NUM_CH);

  logic                 ena;
  logic [NUM_CH-1:0]    ch_req;
  logic [NUM_CH-1:0]    ch_bit;
  logic [NUM_CH-1:0]    ch_shift;
  logic [NUM_CH-1:0]    ch_grant;
  logic [BURST_LEN-1:0] out_data;
  logic [PW-1:0]        out_ch;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    input  ena, ch_req, ch_bit, out_ready,
    output ch_shift, ch_grant, out_data, out_ch, out_valid
  );

  modport slave (
    output ena, ch_req, ch_bit, out_ready,
    input  ch_shift, ch_grant, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/sample_readout_scheduler.sv
// Round-robin readout scheduler: grant, shift one burst, present word.
// SCHED_FIXED_PRIORITY_EN: lowest-index requester always wins, no ptr.
module sample_readout_scheduler #(
  parameter int NUM_CH    = 7,
  parameter int BURST_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  sample_readout_scheduler_if.master bus
);
  localparam int PW = $clog2(NUM_CH);
  localparam int CW = $clog2(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PRESENT
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_CH-1:0]    grant_q, grant_d;
  logic [NUM_CH-1:0]    shift_q, shift_d;
  logic [BURST_LEN-1:0] data_q, data_d;
  logic [PW-1:0]        och_q, och_d;
  logic                 valid_q, valid_d;
  logic [PW-1:0]        base;
  logic                 win_found;
  logic [PW-1:0]        win_idx;

`ifdef SCHED_FIXED_PRIORITY_EN
  assign base = '0;
`else
  logic [PW-1:0] ptr_q, ptr_d;
  assign base = ptr_q;
`endif

  // Search upward from base, wrapping at NUM_CH-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      int j;
      j = int'(base) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!win_found && bus.ch_req[PW'(j)]) begin
        win_found = 1'b1;
        win_idx   = PW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    shift_d = shift_q;
    data_d  = data_q;
    och_d   = och_q;
    valid_d = valid_q;
`ifndef SCHED_FIXED_PRIORITY_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.ena && win_found) begin
          state_d = SHIFT;
          grant_d = NUM_CH'(1) << win_idx;
          shift_d = NUM_CH'(1) << win_idx;
          och_d   = win_idx;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        data_d = {data_q[BURST_LEN-2:0],
                  |(bus.ch_bit & grant_q)};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(BURST_LEN - 1)) begin
          state_d = PRESENT;
          shift_d = '0;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      PRESENT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          grant_d = '0;
`ifndef SCHED_FIXED_PRIORITY_EN
          ptr_d = (och_q == PW'(NUM_CH - 1)) ?
                  '0 : och_q + PW'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      shift_q <= '0;
      data_q  <= '0;
      och_q   <= '0;
      valid_q <= 1'b0;
`ifndef SCHED_FIXED_PRIORITY_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      och_q   <= och_d;
      valid_q <= valid_d;
`ifndef SCHED_FIXED_PRIORITY_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign bus.ch_shift  = shift_q;
  assign bus.ch_grant  = grant_q;
  assign bus.out_data  = data_q;
  assign bus.out_ch    = och_q;
  assign bus.out_valid = valid_q;
endmodule
